// File: rtl/seq_pkg.sv
// Shared state encoding, opcode constants and watchdog limit for the program sequencer.
package seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StIssue,
        StImm,
        StWaitDone,
        StFinish
    } seq_state_e;

    localparam logic [2:0] OPC_MV  = 3'b000;
    localparam logic [2:0] OPC_MVI = 3'b001;
    localparam logic [2:0] OPC_ADD = 3'b010;
    localparam logic [2:0] OPC_SUB = 3'b100;

    localparam int unsigned OPC_HI = 8;
    localparam int unsigned OPC_LO = 6;

    localparam logic [3:0] WD_LIMIT = 4'd15;

    function automatic logic is_mvi(input logic [2:0] opc);
        return opc == OPC_MVI;
    endfunction

endpackage

// File: rtl/seq_pc.sv
// Program counter with clear, +1 and +2 controls; one bit wider than the ROM address
// so a full-length program ends at 2^ADDR_W instead of wrapping.
module seq_pc #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic            Clk,
    input  logic            Resetn,
    input  logic            i_clr,
    input  logic            i_inc1,
    input  logic            i_inc2,
    output logic [ADDR_W:0] o_pc,
    output logic [ADDR_W:0] o_pc_nxt
);

    localparam logic [ADDR_W:0] PC_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] PC_TWO = PC_ONE + PC_ONE;

    logic [ADDR_W:0] r_pc;

    always_comb begin
        o_pc_nxt = r_pc;
        if (i_clr) begin
            o_pc_nxt = '0;
        end else if (i_inc2) begin
            o_pc_nxt = r_pc + PC_TWO;
        end else if (i_inc1) begin
            o_pc_nxt = r_pc + PC_ONE;
        end
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_pc <= '0;
        end else begin
            r_pc <= o_pc_nxt;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/prog_sequencer.sv
// Fetches words from a synchronous ROM and issues them to a processor with a Run pulse.
// Optional watchdog on the Done wait is enabled by defining SEQ_WATCHDOG_EN.
module prog_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned WORD_W = 9
) (
    input  logic              Clk,
    input  logic              Resetn,
    input  logic              Start,
    input  logic [ADDR_W:0]   ProgLen,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic [WORD_W-1:0] MemData,
    output logic [WORD_W-1:0] DIN,
    output logic              Run,
    input  logic              Done,
    output logic              Busy,
    output logic              Finished,
    output logic              Error
);

    seq_state_e        r_state;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [WORD_W-1:0] r_din;
    logic              r_run;
    logic              r_busy;
    logic              r_finished;
    logic              r_error;
    logic              r_is_mvi;
`ifdef SEQ_WATCHDOG_EN
    logic [3:0]        r_wd_cnt;
`endif

    logic [ADDR_W:0]   w_pc;
    logic [ADDR_W:0]   w_pc_nxt;
    logic [ADDR_W:0]   w_pc_plus1;
    logic              w_pc_clr;
    logic              w_step;
    logic              w_inc1;
    logic              w_inc2;
    logic              w_mem_mvi;
    logic              w_din_mvi;

    assign w_pc_clr   = Start && (r_state == StIdle || r_state == StFinish);
    assign w_step     = (r_state == StWaitDone) && Done;
    assign w_inc1     = w_step && !r_is_mvi;
    assign w_inc2     = w_step && r_is_mvi;
    assign w_pc_plus1 = w_pc + {{ADDR_W{1'b0}}, 1'b1};
    assign w_mem_mvi  = is_mvi(MemData[OPC_HI:OPC_LO]);
    assign w_din_mvi  = is_mvi(r_din[OPC_HI:OPC_LO]);

    seq_pc #(
        .ADDR_W (ADDR_W)
    ) u_pc (
        .Clk      (Clk),
        .Resetn   (Resetn),
        .i_clr    (w_pc_clr),
        .i_inc1   (w_inc1),
        .i_inc2   (w_inc2),
        .o_pc     (w_pc),
        .o_pc_nxt (w_pc_nxt)
    );

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_state    <= StIdle;
            r_mem_addr <= '0;
            r_din      <= '0;
            r_run      <= 1'b0;
            r_busy     <= 1'b0;
            r_finished <= 1'b0;
            r_error    <= 1'b0;
            r_is_mvi   <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            r_wd_cnt   <= '0;
`endif
        end else begin
            r_run <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            r_wd_cnt <= '0;
`endif
            unique case (r_state)
                StIdle, StFinish: begin
                    if (Start) begin
                        r_error    <= 1'b0;
                        r_mem_addr <= '0;
                        if (ProgLen == '0) begin
                            r_state    <= StFinish;
                            r_busy     <= 1'b0;
                            r_finished <= 1'b1;
                        end else begin
                            r_state    <= StFetch;
                            r_busy     <= 1'b1;
                            r_finished <= 1'b0;
                        end
                    end
                end
                StFetch: begin
                    r_state <= StLoad;
                end
                StLoad: begin
                    r_din <= MemData;
                    // An MVI with no immediate word left is rejected before Run goes out.
                    if (w_mem_mvi && (w_pc_plus1 >= ProgLen)) begin
                        r_error    <= 1'b1;
                        r_state    <= StFinish;
                        r_busy     <= 1'b0;
                        r_finished <= 1'b1;
                    end else begin
                        r_run      <= 1'b1;
                        r_mem_addr <= w_pc_plus1[ADDR_W-1:0];
                        r_state    <= StIssue;
                    end
                end
                StIssue: begin
                    r_is_mvi <= w_din_mvi;
                    r_state  <= w_din_mvi ? StImm : StWaitDone;
                end
                StImm: begin
                    r_din   <= MemData;
                    r_state <= StWaitDone;
                end
                StWaitDone: begin
                    if (Done) begin
                        if (w_pc_nxt >= ProgLen) begin
                            r_state    <= StFinish;
                            r_busy     <= 1'b0;
                            r_finished <= 1'b1;
                        end else begin
                            r_mem_addr <= w_pc_nxt[ADDR_W-1:0];
                            r_state    <= StFetch;
                        end
                    end
`ifdef SEQ_WATCHDOG_EN
                    else if (r_wd_cnt == WD_LIMIT - 4'd1) begin
                        r_error    <= 1'b1;
                        r_state    <= StFinish;
                        r_busy     <= 1'b0;
                        r_finished <= 1'b1;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 4'd1;
                    end
`endif
                end
                default: begin
                    r_state    <= StIdle;
                    r_busy     <= 1'b0;
                    r_finished <= 1'b0;
                end
            endcase
        end
    end

    assign MemAddr  = r_mem_addr;
    assign DIN      = r_din;
    assign Run      = r_run;
    assign Busy     = r_busy;
    assign Finished = r_finished;
    assign Error    = r_error;

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: a ROM model, a processor model and per-scenario tasks.
module tb_prog_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [5:0] prog_len;
    logic [4:0] mem_addr;
    logic [8:0] mem_data;
    logic [8:0] din;
    logic       run;
    logic       done;
    logic       busy;
    logic       finished;
    logic       error;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [8:0] word;
        logic [4:0] addr;
        logic       mvi;
        logic [8:0] imm;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       cur;
    int         imm_dly = -1;
    logic       run_prev = 1'b0;
    int         run_cnt = 0;

    logic [8:0] rom [32];
    int         proc_lat = 2;
    bit         proc_en = 1'b1;
    int         p_cnt = -1;

    prog_sequencer dut (
        .Clk      (clk),
        .Resetn   (rst_n),
        .Start    (start),
        .ProgLen  (prog_len),
        .MemAddr  (mem_addr),
        .MemData  (mem_data),
        .DIN      (din),
        .Run      (run),
        .Done     (done),
        .Busy     (busy),
        .Finished (finished),
        .Error    (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous ROM: data valid the cycle after the address.
    always @(posedge clk) mem_data <= rom[mem_addr];

    // Processor: Done pulses proc_lat+1 cycles after the Run cycle.
    always @(negedge clk) begin
        done = 1'b0;
        if (!rst_n) begin
            p_cnt = -1;
        end else begin
            if (p_cnt == 0) begin
                done  = 1'b1;
                p_cnt = -1;
            end else if (p_cnt > 0) begin
                p_cnt--;
            end
            if (run === 1'b1 && proc_en) p_cnt = proc_lat;
        end
    end

    // Scoreboard monitor for Run pulses and the MVI immediate on DIN.
    always @(negedge clk) begin
        if (!rst_n) begin
            imm_dly  = -1;
            run_prev = 1'b0;
        end else begin
            if (imm_dly == 0) begin
                total++;
                if (din !== cur.imm) begin
                    bad++;
                    $display("FAIL imm_on_din got=%h want=%h", din, cur.imm);
                end
            end
            if (imm_dly >= 0) imm_dly--;
            if (run === 1'b1) begin
                run_cnt++;
                total++;
                if (run_prev) begin
                    bad++;
                    $display("FAIL run_consecutive got=1 want=0");
                end
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL run_unexpected got din=%h addr=%0d want no run", din, mem_addr);
                end else begin
                    cur = sb_q.pop_front();
                    if (din !== cur.word || mem_addr !== cur.addr) begin
                        bad++;
                        $display("FAIL run_word got din=%h addr=%0d want din=%h addr=%0d",
                                 din, mem_addr, cur.word, cur.addr);
                    end
                    if (cur.mvi) imm_dly = 1;
                end
            end
            run_prev = run;
        end
    end

    // Walks the loaded program and queues the Run pulses it should produce.
    task automatic load_expect(output logic [5:0] fin_pc, output logic exp_err);
        logic [5:0] pc;
        logic [4:0] nxt;
        logic [8:0] w;
        exp_t       e;
        pc      = '0;
        exp_err = 1'b0;
        while (pc < prog_len) begin
            w = rom[pc[4:0]];
            if (w[8:6] == 3'b001 && (pc + 6'd1) >= prog_len) begin
                exp_err = 1'b1;
                break;
            end
            nxt    = pc[4:0] + 5'd1;
            e.word = w;
            e.addr = nxt;
            e.mvi  = (w[8:6] == 3'b001);
            e.imm  = rom[nxt];
            sb_q.push_back(e);
            pc = pc + (e.mvi ? 6'd2 : 6'd1);
        end
        fin_pc = pc;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic go_and_wait(input int budget, output bit to);
        to = 1'b1;
        pulse_start();
        for (int i = 0; i < budget; i++) begin
            if (finished === 1'b1) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_run(input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (run === 1'b1) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        prog_len = '0;
        #3;
        total++;
        if ({mem_addr, din, run, busy, finished, error} !== 18'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {mem_addr, din, run, busy, finished, error});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || finished !== 1'b0 || run !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset got busy=%b fin=%b run=%b want 0 0 0",
                     busy, finished, run);
        end
    endtask

    task automatic test_zero_len();
        bit to;
        prog_len = 6'd0;
        run_cnt  = 0;
        go_and_wait(1, to);
        total++;
        if (to || busy !== 1'b0 || error !== 1'b0) begin
            bad++;
            $display("FAIL zero_len got to=%b fin=%b busy=%b err=%b want 0 1 0 0",
                     to, finished, busy, error);
        end
        repeat (3) @(negedge clk);
        total++;
        if (finished !== 1'b1 || run_cnt != 0) begin
            bad++;
            $display("FAIL zero_len_hold got fin=%b runs=%0d want 1 0", finished, run_cnt);
        end
    endtask

    task automatic test_mvi_prog();
        bit         to;
        logic [5:0] fpc;
        logic       ferr;
        rom[0]   = 9'b001000000;
        rom[1]   = 9'h005;
        rom[2]   = 9'b010000000;
        prog_len = 6'd3;
        proc_lat = 2;
        run_cnt  = 0;
        load_expect(fpc, ferr);
        go_and_wait(60, to);
        total++;
        if (to || error !== 1'b0 || dut.w_pc !== 6'd3 || run_cnt != 2 || sb_q.size() != 0) begin
            bad++;
            $display("FAIL mvi_prog got to=%b err=%b pc=%0d runs=%0d left=%0d want 0 0 3 2 0",
                     to, error, dut.w_pc, run_cnt, sb_q.size());
        end
    endtask

    task automatic test_mvi_last();
        bit         to;
        logic [5:0] fpc;
        logic       ferr;
        rom[0]   = 9'b001000000;
        prog_len = 6'd1;
        run_cnt  = 0;
        load_expect(fpc, ferr);
        go_and_wait(20, to);
        total++;
        if (to || error !== 1'b1 || run_cnt != 0) begin
            bad++;
            $display("FAIL mvi_only got to=%b err=%b runs=%0d want 0 1 0", to, error, run_cnt);
        end
        rom[0]   = 9'h000;
        rom[1]   = 9'h07f;
        prog_len = 6'd2;
        run_cnt  = 0;
        load_expect(fpc, ferr);
        go_and_wait(40, to);
        total++;
        if (to || error !== 1'b1 || run_cnt != 1 || dut.w_pc !== 6'd1) begin
            bad++;
            $display("FAIL mvi_tail got to=%b err=%b runs=%0d pc=%0d want 0 1 1 1",
                     to, error, run_cnt, dut.w_pc);
        end
        prog_len = 6'd0;
        go_and_wait(1, to);
        total++;
        if (to || error !== 1'b0) begin
            bad++;
            $display("FAIL error_clear got to=%b err=%b want 0 0", to, error);
        end
    endtask

    task automatic test_start_busy();
        bit         to;
        logic [5:0] fpc;
        logic       ferr;
        rom[0]   = 9'h000;
        rom[1]   = 9'h080;
        rom[2]   = 9'h100;
        rom[3]   = 9'h091;
        prog_len = 6'd4;
        proc_lat = 3;
        run_cnt  = 0;
        load_expect(fpc, ferr);
        pulse_start();
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (finished === 1'b1) begin
                to = 1'b0;
                break;
            end
            start = (i % 3 == 0);
            @(negedge clk);
            start = 1'b0;
        end
        start = 1'b0;
        total++;
        if (to || error !== 1'b0 || run_cnt != 4 || sb_q.size() != 0 || dut.w_pc !== 6'd4) begin
            bad++;
            $display("FAIL start_busy got to=%b err=%b runs=%0d left=%0d pc=%0d want 0 0 4 0 4",
                     to, error, run_cnt, sb_q.size(), dut.w_pc);
        end
    endtask

    task automatic test_reset_midrun();
        bit         to;
        logic [5:0] fpc;
        logic       ferr;
        rom[0]   = 9'h080;
        rom[1]   = 9'h000;
        rom[2]   = 9'h100;
        prog_len = 6'd3;
        proc_lat = 6;
        run_cnt  = 0;
        load_expect(fpc, ferr);
        pulse_start();
        wait_run(20, to);
        @(negedge clk);
        total++;
        if (to || busy !== 1'b1) begin
            bad++;
            $display("FAIL midrun_reach got to=%b busy=%b want 0 1", to, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({mem_addr, din, run, busy, finished, error} !== 18'd0) begin
            bad++;
            $display("FAIL midrun_reset got=%h want=0", {mem_addr, din, run, busy, finished, error});
        end
        sb_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        total++;
        if (run_cnt != 1 || busy !== 1'b0 || finished !== 1'b0) begin
            bad++;
            $display("FAIL midrun_abort got runs=%0d busy=%b fin=%b want 1 0 0",
                     run_cnt, busy, finished);
        end
        run_cnt = 0;
        load_expect(fpc, ferr);
        go_and_wait(80, to);
        total++;
        if (to || run_cnt != 3 || sb_q.size() != 0 || dut.w_pc !== 6'd3) begin
            bad++;
            $display("FAIL midrun_rerun got to=%b runs=%0d left=%0d pc=%0d want 0 3 0 3",
                     to, run_cnt, sb_q.size(), dut.w_pc);
        end
    endtask

    task automatic test_full_len();
        bit         to;
        logic [5:0] fpc;
        logic       ferr;
        for (int i = 0; i < 32; i++) rom[i] = 9'h080 | 9'(i);
        prog_len = 6'd32;
        proc_lat = 0;
        run_cnt  = 0;
        load_expect(fpc, ferr);
        go_and_wait(400, to);
        total++;
        if (to || error !== 1'b0 || run_cnt != 32 || dut.w_pc !== 6'd32 || mem_addr !== 5'd0) begin
            bad++;
            $display("FAIL full_len got to=%b err=%b runs=%0d pc=%0d addr=%0d want 0 0 32 32 0",
                     to, error, run_cnt, dut.w_pc, mem_addr);
        end
    endtask

    task automatic test_random();
        bit         to;
        logic [5:0] fpc;
        logic       ferr;
        logic [2:0] opcs [4];
        opcs[0] = 3'b000;
        opcs[1] = 3'b001;
        opcs[2] = 3'b010;
        opcs[3] = 3'b100;
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 32; i++) begin
                rom[i] = {opcs[$urandom_range(0, 3)], 6'($urandom_range(0, 63))};
            end
            prog_len = 6'($urandom_range(1, 32));
            proc_lat = $urandom_range(0, 4);
            load_expect(fpc, ferr);
            go_and_wait(500, to);
            total++;
            if (to || error !== ferr || dut.w_pc !== fpc || sb_q.size() != 0) begin
                bad++;
                $display("FAIL random_%0d got to=%b err=%b pc=%0d left=%0d want 0 %b %0d 0",
                         n, to, error, dut.w_pc, sb_q.size(), ferr, fpc);
            end
            sb_q.delete();
        end
    endtask

    task automatic test_watchdog();
        bit         to;
        logic [5:0] fpc;
        logic       ferr;
        rom[0]   = 9'h080;
        prog_len = 6'd1;
        proc_en  = 1'b0;
        load_expect(fpc, ferr);
        pulse_start();
        wait_run(20, to);
        total++;
        if (to) begin
            bad++;
            $display("FAIL wd_run got no run want run");
        end
`ifdef SEQ_WATCHDOG_EN
        repeat (15) @(negedge clk);
        total++;
        if (finished !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL wd_early got fin=%b busy=%b want 0 1", finished, busy);
        end
        @(negedge clk);
        total++;
        if (finished !== 1'b1 || error !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL wd_fire got fin=%b err=%b busy=%b want 1 1 0", finished, error, busy);
        end
`else
        repeat (40) @(negedge clk);
        total++;
        if (finished !== 1'b0 || busy !== 1'b1 || error !== 1'b0) begin
            bad++;
            $display("FAIL wd_hold got fin=%b busy=%b err=%b want 0 1 0", finished, busy, error);
        end
        #2;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
`endif
        proc_en = 1'b1;
        sb_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = '0;
        test_reset();
        test_zero_len();
        test_mvi_prog();
        test_mvi_last();
        test_start_busy();
        test_reset_midrun();
        test_full_len();
        test_random();
        test_watchdog();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, meaning program-memory address width.
REQ-002 SHALL have parameter WORD_W, default 9, meaning instruction/data word width.
REQ-003 SHALL have port Clk, input, 1 bit, system clock; all state changes on its rising edge.
REQ-004 SHALL have port Resetn, input, 1 bit, reset; asynchronous, active-low.
REQ-005 SHALL have port Start, input, 1 bit, begin executing the program from address 0 when idle.
REQ-006 SHALL have port ProgLen, input, ADDR_W+1 bits, number of program words, 0..2^ADDR_W.
REQ-007 SHALL have port MemAddr, output, ADDR_W bits, synchronous ROM address; read data is valid one cycle later.
REQ-008 SHALL have port MemData, input, WORD_W bits, ROM read data.
REQ-009 SHALL have port DIN, output, WORD_W bits, registered word presented to the processor.
REQ-010 SHALL have port Run, output, 1 bit, one-cycle start pulse to the processor.
REQ-011 SHALL have port Done, input, 1 bit, processor instruction-complete level.
REQ-012 SHALL have port Busy, output, 1 bit, high in every state except IDLE and FINISH.
REQ-013 SHALL have port Finished, output, 1 bit, high in FINISH.
REQ-014 SHALL have port Error, output, 1 bit, sticky fault flag, cleared only by Start or reset.

Function
REQ-015 SHALL implement states IDLE, FETCH, LOAD, ISSUE, IMM, WAIT_DONE and FINISH.
REQ-016 IDLE: when Start=1, SHALL clear PC and Error, then go to FINISH if ProgLen=0, else go to FETCH.
REQ-017 FETCH: MemAddr=PC[ADDR_W-1:0] -> LOAD.
REQ-018 LOAD: DIN<=MemData at cycle end -> ISSUE.
REQ-019 ISSUE: Run=1 for exactly this cycle; MemAddr=PC+1 (immediate prefetch); if DIN[8:6]=3'b001 (MVI) -> IMM, else -> WAIT_DONE.
REQ-020 IMM: DIN<=MemData at cycle end, so the immediate is on DIN two cycles after the Run cycle (processor step T2) -> WAIT_DONE.
REQ-021 WAIT_DONE: DIN SHALL be held; on Done=1, PC<=PC+2 for MVI or PC+1 otherwise; next state is FINISH if the new PC>=ProgLen, else FETCH.
REQ-022 MVI at the last word (PC+1=ProgLen) SHALL set Error and go to FINISH without asserting Run.
REQ-023 Start SHALL be ignored outside IDLE and FINISH; Start in FINISH SHALL behave as in IDLE.
REQ-024 PC SHALL be ADDR_W+1 bits wide; a program of 2^ADDR_W words SHALL terminate without address wrap.
REQ-025 Done seen outside WAIT_DONE SHALL be ignored.
REQ-026 Run SHALL never be asserted in two consecutive cycles.

Reset
REQ-027 On Resetn=0, asynchronously: state=IDLE, PC=0, MemAddr=0, DIN=0, Run=0, Busy=0, Finished=0, Error=0, watchdog count=0.
REQ-028 Reset mid-instruction SHALL abort with no further Run pulse until a new Start.

Configuration
REQ-029 Macro SEQ_WATCHDOG_EN defined: a 4-bit counter SHALL count WAIT_DONE cycles; Done absent for 15 cycles SHALL set Error and go to FINISH.
REQ-030 SEQ_WATCHDOG_EN undefined: no counter SHALL exist, and WAIT_DONE SHALL wait indefinitely.

Structure
REQ-031 Package seq_pkg SHALL hold the state enum, opcode constants (MV=000, MVI=001, ADD=010, SUB=100), the opcode field position [8:6] and the watchdog limit.
REQ-032 Sub-module seq_pc SHALL implement the loadable PC with clear, +1 and +2 controls.

Verification
REQ-033 ProgLen=0 with Start pulse -> FINISH in the next cycle, Run never asserted, Error=0.
REQ-034 ROM {MVI R0 (001000000), 0x05, ADD R0,R0 (010000000)}, ProgLen=3, processor model -> Run pulses at instruction word 0 and word 2; DIN=0x05 exactly two cycles after the first Run; Finished=1 with PC=3.
REQ-035 MVI as the only word (ProgLen=1) -> Error=1, Finished=1, zero Run pulses.
REQ-036 Start pulsed while Busy -> no effect; program completes normally.
REQ-037 Resetn low during WAIT_DONE -> all outputs 0 immediately; a new Start re-executes from address 0.
REQ-038 SEQ_WATCHDOG_EN defined, Done held 0 -> Error=1 and FINISH 15 cycles after entering WAIT_DONE; macro undefined -> remains in WAIT_DONE.
